// File: rtl/lifo_arbiter.sv
// Two-port arbiter in front of a 16-entry LIFO: latches push/pop requests, grants one at a time,
// drives the LIFO strobes and tracks occupancy. Define LIFO_ARB_RR_EN for round-robin arbitration.
module lifo_arbiter #(
    parameter int DW    = 11,
    parameter int DEPTH = 15,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    req_i,
    input  logic [1:0]    op_i,
    input  logic [DW-1:0] wdata0_i,
    input  logic [DW-1:0] wdata1_i,
    output logic [1:0]    busy_o,
    output logic [1:0]    ack_o,
    output logic          err_o,
    output logic [DW-1:0] rdata_o,
    output logic          lifo_wr_en,
    output logic          lifo_rd_en,
    output logic [DW-1:0] lifo_din,
    input  logic [DW-1:0] lifo_dout,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE, RESP} state_t;

    state_t             state_reg, state_next;
    logic [1:0]         eligible;
    logic [1:0]         sel_op;
    logic [1:0][DW-1:0] sel_data;
    logic [1:0][DW-1:0] wdata_in;
    logic [1:0]         pend;
    logic [1:0]         clr_pend;
    logic               grant;

    logic               winner_reg;
    logic               op_reg;
    logic [DW-1:0]      data_reg;
    logic               err_flag_reg;
    logic [CW-1:0]      count_reg;
    logic [DW-1:0]      rdata_reg;
    logic [1:0]         ack_reg;
    logic               err_reg;

    logic               load, do_push, do_pop, set_err, capture, respond;
    logic               has_room, has_data;

    assign wdata_in = {wdata1_i, wdata0_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic          pend_reg;
            logic          op_pend_reg;
            logic [DW-1:0] wdata_pend_reg;

            // A request seen while already pending is dropped, not queued.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    pend_reg       <= 1'b0;
                    op_pend_reg    <= 1'b0;
                    wdata_pend_reg <= '0;
                end else if (clr_pend[gi]) begin
                    pend_reg <= 1'b0;
                end else if (req_i[gi] && !pend_reg) begin
                    pend_reg       <= 1'b1;
                    op_pend_reg    <= op_i[gi];
                    wdata_pend_reg <= wdata_in[gi];
                end
            end

            // Same-cycle requests bypass the latch so IDLE can grant them immediately.
            assign pend[gi]     = pend_reg;
            assign eligible[gi] = pend_reg | req_i[gi];
            assign sel_op[gi]   = pend_reg ? op_pend_reg : op_i[gi];
            assign sel_data[gi] = pend_reg ? wdata_pend_reg : wdata_in[gi];
        end
    endgenerate

`ifdef LIFO_ARB_RR_EN
    logic last_reg;

    always_comb begin
        if (eligible == 2'b11) grant = ~last_reg;
        else                   grant = ~eligible[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)       last_reg <= 1'b1;
        else if (load) last_reg <= grant;
    end
`else
    assign grant = ~eligible[0];
`endif

    assign has_room = (count_reg < CW'(DEPTH));
    assign has_data = (count_reg != '0);

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        set_err    = 1'b0;
        capture    = 1'b0;
        respond    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|eligible) begin
                    load       = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                if (op_reg) begin
                    if (has_room) do_push = 1'b1;
                    else          set_err = 1'b1;
                    state_next = RESP;
                end else if (has_data) begin
                    do_pop     = 1'b1;
                    state_next = CAPTURE;
                end else begin
                    set_err    = 1'b1;
                    state_next = RESP;
                end
            end
            CAPTURE: begin
                capture    = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                respond    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign clr_pend = respond ? (winner_reg ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            winner_reg   <= 1'b0;
            op_reg       <= 1'b0;
            data_reg     <= '0;
            err_flag_reg <= 1'b0;
            count_reg    <= '0;
            rdata_reg    <= '0;
            ack_reg      <= 2'b00;
            err_reg      <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load) begin
                winner_reg   <= grant;
                op_reg       <= sel_op[grant];
                data_reg     <= sel_data[grant];
                err_flag_reg <= 1'b0;
            end
            if (set_err) err_flag_reg <= 1'b1;
            if (do_push)     count_reg <= count_reg + 1'b1;
            else if (do_pop) count_reg <= count_reg - 1'b1;
            // LIFO dout already shows the popped entry one cycle after rd_en.
            if (capture) rdata_reg <= lifo_dout;
            ack_reg <= clr_pend;
            err_reg <= respond & err_flag_reg;
        end
    end

    assign busy_o     = pend;
    assign ack_o      = ack_reg;
    assign err_o      = err_reg;
    assign rdata_o    = rdata_reg;
    assign lifo_wr_en = do_push;
    assign lifo_rd_en = do_pop;
    assign lifo_din   = data_reg;
    assign count_o    = count_reg;
    assign full_o     = (count_reg == CW'(DEPTH));
    assign empty_o    = (count_reg == '0);

endmodule

// File: tb/tb_lifo_arbiter.sv
// Scoreboard bench for lifo_arbiter with a behavioural 16-entry LIFO attached.
module tb_lifo_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req_i = 2'b00;
    logic [1:0]  op_i = 2'b00;
    logic [10:0] wdata0_i = '0;
    logic [10:0] wdata1_i = '0;
    logic [1:0]  busy_o, ack_o;
    logic        err_o;
    logic [10:0] rdata_o;
    logic        lifo_wr_en, lifo_rd_en;
    logic [10:0] lifo_din, lifo_dout;
    logic [3:0]  count_o;
    logic        full_o, empty_o;

    lifo_arbiter #(.DW(11), .DEPTH(15), .CW(4)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .op_i(op_i),
        .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
        .busy_o(busy_o), .ack_o(ack_o), .err_o(err_o), .rdata_o(rdata_o),
        .lifo_wr_en(lifo_wr_en), .lifo_rd_en(lifo_rd_en),
        .lifo_din(lifo_din), .lifo_dout(lifo_dout),
        .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
    );

    always #5 clk = ~clk;

    // Behavioural LIFO: synchronous reset of the address, combinational read.
    logic [10:0] ram [16];
    logic [3:0]  addr;
    assign lifo_dout = ram[addr];
    always @(posedge clk) begin
        if (rst) addr <= 4'd0;
        else if (lifo_wr_en) begin
            ram[addr] <= lifo_din;
            addr      <= addr + 4'd1;
        end else if (lifo_rd_en) addr <= addr - 4'd1;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [1:0]  ack;
        logic        err;
        logic        chk_data;
        logic [10:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [10:0] stack[$];
    int          checks = 0;
    int          passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Monitor: pops one expectation per ack pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (ack_o != 2'b00) begin
                if (sb.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_ack: got ack=%b expected none (cycle %0d)", ack_o, cyc);
                end else begin
                    e = sb.pop_front();
                    $display("ack port=%b err=%b rdata=%h count=%0d cycle=%0d", ack_o, err_o, rdata_o, count_o, cyc);
                    check("ack_port", 32'(ack_o), 32'(e.ack));
                    check("ack_err", 32'(err_o), 32'(e.err));
                    check("ack_cycle", cyc, e.cyc);
                    if (e.chk_data) check("pop_rdata", 32'(rdata_o), 32'(e.data));
                end
            end else if (err_o !== 1'b0) begin
                checks++;
                $display("FAIL err_without_ack: got err=%b expected 0 (cycle %0d)", err_o, cyc);
            end
        end
    end

    task automatic wait_drain();
        for (int i = 0; i < 30 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sb.size() != 0) begin
            checks++;
            $display("FAIL ack_timeout: got %0d outstanding expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic check_occupancy();
        check("count", 32'(count_o), stack.size());
        check("full", 32'(full_o), 32'(stack.size() == 15));
        check("empty", 32'(empty_o), 32'(stack.size() == 0));
    endtask

    task automatic do_op(input int port, input bit push, input logic [10:0] data);
        exp_t e;
        bit   ok;
        @(posedge clk);
        #1;
        ok = push ? (stack.size() < 15) : (stack.size() > 0);
        e.ack      = (port == 1) ? 2'b10 : 2'b01;
        e.err      = !ok;
        e.chk_data = !push && ok;
        e.data     = '0;
        e.cyc      = cyc + ((!push && ok) ? 4 : 3);
        if (push && ok) stack.push_back(data);
        if (!push && ok) e.data = stack.pop_back();
        sb.push_back(e);
        req_i[port] = 1'b1;
        op_i[port]  = push;
        if (port == 1) wdata1_i = data;
        else           wdata0_i = data;
        @(posedge clk);
        #1;
        req_i = 2'b00;
        @(negedge clk);
        check("wr_en_T1", 32'(lifo_wr_en), 32'(push && ok));
        check("rd_en_T1", 32'(lifo_rd_en), 32'(!push && ok));
        if (push && ok) check("din_T1", 32'(lifo_din), 32'(data));
        wait_drain();
        check_occupancy();
    endtask

    task automatic push_exp(input logic [1:0] ack, input int at);
        exp_t e;
        e.ack = ack; e.err = 1'b0; e.chk_data = 1'b0; e.data = '0; e.cyc = at;
        sb.push_back(e);
    endtask

    initial begin
        int t0;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", 32'(ack_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_err", 32'(err_o), 0);
        check("rst_rdata", 32'(rdata_o), 0);
        check("rst_strobes", 32'({lifo_wr_en, lifo_rd_en}), 0);
        check("rst_count", 32'(count_o), 0);
        check("rst_empty", 32'(empty_o), 1);
        check("rst_full", 32'(full_o), 0);
        rst = 1'b0;

        // Basic push/pop on both ports, then pop when empty.
        do_op(0, 1'b1, 11'h155);
        do_op(0, 1'b0, 11'h000);
        do_op(0, 1'b1, 11'h0AA);
        do_op(1, 1'b0, 11'h000);
        do_op(0, 1'b0, 11'h000);
        check("rdata_hold", 32'(rdata_o), 32'h0AA);

        // Fill to DEPTH, overflow, then drain in reverse order.
        for (int i = 1; i <= 15; i++) do_op(0, 1'b1, 11'(i));
        do_op(0, 1'b1, 11'h7FF);
        for (int i = 0; i < 15; i++) do_op(1, 1'b0, 11'h000);

        // Simultaneous pushes: port 0 first in both modes.
        @(posedge clk);
        #1;
        t0 = cyc;
        push_exp(2'b01, t0 + 3);
        push_exp(2'b10, t0 + 6);
        stack.push_back(11'h100);
        stack.push_back(11'h200);
        req_i = 2'b11; op_i = 2'b11; wdata0_i = 11'h100; wdata1_i = 11'h200;
        @(posedge clk);
        #1;
        req_i = 2'b00;
        wait_drain();
        check_occupancy();

        // Port 0 re-requests on each of its first two acks.
        @(posedge clk);
        #1;
        t0 = cyc;
`ifdef LIFO_ARB_RR_EN
        push_exp(2'b01, t0 + 3);
        push_exp(2'b10, t0 + 6);
        push_exp(2'b01, t0 + 9);
        push_exp(2'b01, t0 + 12);
        stack.push_back(11'h011); stack.push_back(11'h0F1);
        stack.push_back(11'h012); stack.push_back(11'h013);
`else
        push_exp(2'b01, t0 + 3);
        push_exp(2'b01, t0 + 6);
        push_exp(2'b01, t0 + 9);
        push_exp(2'b10, t0 + 12);
        stack.push_back(11'h011); stack.push_back(11'h012);
        stack.push_back(11'h013); stack.push_back(11'h0F1);
`endif
        req_i = 2'b11; op_i = 2'b11; wdata0_i = 11'h011; wdata1_i = 11'h0F1;
        @(posedge clk);
        #1;
        req_i = 2'b00;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (ack_o[0] && n < 2) begin
                req_i[0] = 1'b1; op_i[0] = 1'b1; wdata0_i = 11'h012 + 11'(n);
                n++;
            end else req_i[0] = 1'b0;
        end
        req_i = 2'b00;
        wait_drain();
        check_occupancy();
        while (stack.size() > 0) do_op(0, 1'b0, 11'h000);

        // Reset during CAPTURE of a pop: no ack, state cleared asynchronously.
        do_op(0, 1'b1, 11'h3C3);
        do_op(0, 1'b1, 11'h1E1);
        @(posedge clk);
        #1;
        req_i[1] = 1'b1; op_i[1] = 1'b0;
        @(posedge clk);
        #1;
        req_i = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("arst_busy", 32'(busy_o), 0);
        check("arst_count", 32'(count_o), 0);
        check("arst_empty", 32'(empty_o), 1);
        check("arst_ack", 32'(ack_o), 0);
        stack.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        do_op(0, 1'b1, 11'h2B4);
        check("slot0_after_rst", 32'(ram[0]), 32'h2B4);
        do_op(1, 1'b0, 11'h000);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
